// File: rtl/MemMap.sv
// MemMap: system address map constants and decode helpers shared by the
// data-side address decoder and the devices it serves.
//
// Contents:
//   CLINT_OFFSET / CLINT_END : byte-address window of the CLINT timer
//   clint_reg_e              : register selector inside the CLINT window
//   is_clint(addr)           : 1 when addr is inside the window and word aligned
//   clint_reg(addr)          : register addressed by a legal CLINT address
package MemMap;

    localparam logic [31:0] CLINT_OFFSET = 32'hF000_0000;
    localparam logic [31:0] CLINT_SIZE   = 32'h0000_0010;
    localparam logic [31:0] CLINT_END    = CLINT_OFFSET + CLINT_SIZE;

    typedef enum logic [1:0] {
        MTIME     = 2'd0,
        MTIMEH    = 2'd1,
        MTIMECMP  = 2'd2,
        MTIMECMPH = 2'd3
    } clint_reg_e;

    function automatic logic is_clint(input logic [31:0] addr);
        return (addr >= CLINT_OFFSET) && (addr < CLINT_END) && (addr[1:0] == 2'b00);
    endfunction

    // Only meaningful when is_clint(addr) holds; the window is 16 bytes and
    // word aligned, so the word index is the low offset bits [3:2].
    function automatic clint_reg_e clint_reg(input logic [31:0] addr);
        logic [1:0] word;
        word = addr[3:2] - CLINT_OFFSET[3:2];
        return clint_reg_e'(word);
    endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// clint_mtime_counter: prescaled 64-bit mtime counter with half-word writes.
//
// Parameters:
//   TICK_DIV  clk cycles per mtime increment (1..65535)
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (mtime and prescaler to 0)
//   wr_lo_i   write wdata_i into mtime[31:0]
//   wr_hi_i   write wdata_i into mtime[63:32]
//   wdata_i   write data
//   mtime_o   current mtime register value
module clint_mtime_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 16'd1;
        mtime_d = mtime_q;
        // A write owns the whole cycle: the tick is dropped, including any
        // carry into the half that is not being written. The prescaler keeps
        // running regardless.
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) mtime_d[31:0]  = wdata_i;
            if (wr_hi_i) mtime_d[63:32] = wdata_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped CLINT timer (mtime / mtimecmp / mtip).
//
// Parameters:
//   TICK_DIV    clk cycles per mtime increment (1..65535)
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   req_valid   request present
//   req_ready   device can accept a request (IDLE and not in reset)
//   req_addr    absolute byte address
//   req_wen     1 = write, 0 = read
//   req_wdata   write data
//   resp_valid  one-cycle response pulse, the cycle after acceptance
//   resp_error  illegal address; qualified by resp_valid
//   resp_rdata  read data (0 on error); qualified by resp_valid
//   mtip        registered mtime >= mtimecmp
module clint_timer
    import MemMap::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mtip
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        mtip_q, mtip_d;

    logic        accept;
    logic        legal;
    clint_reg_e  reg_sel;
    logic        mtime_wr_lo, mtime_wr_hi;
    logic [63:0] mtime;

    assign req_ready = (state_q == IDLE) && !reset;

    clint_mtime_counter #(
        .TICK_DIV(TICK_DIV)
    ) u_mtime (
        .clk_i   (clk),
        .rst_i   (reset),
        .wr_lo_i (mtime_wr_lo),
        .wr_hi_i (mtime_wr_hi),
        .wdata_i (req_wdata),
        .mtime_o (mtime)
    );

    always_comb begin
        state_d      = state_q;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        mtimecmp_d   = mtimecmp_q;
        mtime_wr_lo  = 1'b0;
        mtime_wr_hi  = 1'b0;

        accept  = req_valid && req_ready;
        legal   = is_clint(req_addr);
        reg_sel = clint_reg(req_addr);

        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            resp_error_d = !legal;
            resp_rdata_d = '0;
            if (legal) begin
                if (!req_wen) begin
                    // Read data is the pre-edge register value.
                    case (reg_sel)
                        MTIME:     resp_rdata_d = mtime[31:0];
                        MTIMEH:    resp_rdata_d = mtime[63:32];
                        MTIMECMP:  resp_rdata_d = mtimecmp_q[31:0];
                        MTIMECMPH: resp_rdata_d = mtimecmp_q[63:32];
                        default:   resp_rdata_d = '0;
                    endcase
                end else begin
                    case (reg_sel)
                        MTIME:     mtime_wr_lo = 1'b1;
                        MTIMEH:    mtime_wr_hi = 1'b1;
                        MTIMECMP:  mtimecmp_d[31:0]  = req_wdata;
                        MTIMECMPH: mtimecmp_d[63:32] = req_wdata;
                        default:   ;
                    endcase
                end
            end
        end

        mtip_d = (mtime >= mtimecmp_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mtimecmp_q   <= '1;
            mtip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mtimecmp_q   <= mtimecmp_d;
            mtip_q       <= mtip_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign mtip       = mtip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: two instances (TICK_DIV=1 and 4) share
// the request bus; sel chooses which one receives req_valid and is monitored.
module tb_clint_timer;

    localparam logic [31:0] A_MT   = 32'hF000_0000;
    localparam logic [31:0] A_MTH  = 32'hF000_0004;
    localparam logic [31:0] A_CMP  = 32'hF000_0008;
    localparam logic [31:0] A_CMPH = 32'hF000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        sel = 1'b0;

    logic        rv1, rv4;
    logic        rdy1, rdy4, rsv1, rsv4, err1, err4, mtip1, mtip4;
    logic [31:0] rd1, rd4;
    logic        m_rdy, m_rsv, m_err, m_mtip;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    assign rv1     = req_valid & ~sel;
    assign rv4     = req_valid & sel;
    assign m_rdy   = sel ? rdy4  : rdy1;
    assign m_rsv   = sel ? rsv4  : rsv1;
    assign m_err   = sel ? err4  : err1;
    assign m_rdata = sel ? rd4   : rd1;
    assign m_mtip  = sel ? mtip4 : mtip1;

    clint_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .resp_valid(rsv1), .resp_error(err1), .resp_rdata(rd1), .mtip(mtip1)
    );

    clint_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rdy4),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .resp_valid(rsv4), .resp_error(err4), .resp_rdata(rd4), .mtip(mtip4)
    );

    typedef struct {
        logic        err;
        logic        chkd;
        logic [31:0] data;
        int unsigned tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned tag_n = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mtip_mid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per response pulse.
    always @(negedge clk) begin
        if (m_rsv === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("resp%0d_err", mon_e.tag), 64'(m_err), 64'(mon_e.err));
                if (mon_e.chkd)
                    chk($sformatf("resp%0d_rdata", mon_e.tag), 64'(m_rdata), 64'(mon_e.data));
            end
        end
    end

    task automatic push_exp(input logic e, input logic c, input logic [31:0] d);
        exp_t t;
        t.err  = e;
        t.chkd = c;
        t.data = d;
        t.tag  = tag_n;
        tag_n++;
        sb.push_back(t);
    endtask

    // Called just after a negedge; returns just after the negedge that
    // precedes the next possible accept edge (two edges later).
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic eerr, input logic echk, input logic [31:0] edata);
        chk("ready_idle", 64'(m_rdy), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        push_exp(eerr, echk, edata);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("ready_busy", 64'(m_rdy), 64'd0);
        mtip_mid = m_mtip;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] edata);
        access(a, 1'b0, 32'h0, 1'b0, 1'b1, edata);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(a, 1'b1, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic bad(input logic [31:0] a, input logic w);
        access(a, w, 32'h0000_DEAD, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_reset_div1", 64'(rdy1), 64'd0);
            chk("ready_in_reset_div4", 64'(rdy4), 64'd0);
        end
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- TICK_DIV = 1 ----------------
        sel = 1'b0;
        do_reset();
        rd(A_CMP,  32'hFFFF_FFFF);             // edge 1
        rd(A_CMPH, 32'hFFFF_FFFF);             // edge 3
        chk("mtip_reset", 64'(m_mtip), 64'd0);
        rd(A_MT, 32'd4);                       // edge 5
        rd(A_MT, 32'd6);                       // edge 7
        rd(A_MTH, 32'd0);                      // edge 9

        wr(A_CMPH, 32'h0);                     // edge 11
        wr(A_CMP, 32'h40);                     // edge 13
        wr(A_MT, 32'h30);                      // edge 15: mtime=0x40 after edge 31
        idle(15);                              // before edge 32
        chk("mtip_before", 64'(m_mtip), 64'd0);
        idle(1);                               // before edge 33
        chk("mtip_set", 64'(m_mtip), 64'd1);
        wr(A_CMP, 32'hFFFF_FFFF);              // edge 33
        chk("mtip_hold_e1", 64'(mtip_mid), 64'd1);
        chk("mtip_drop", 64'(m_mtip), 64'd0);

        wr(A_MTH, 32'h0);                      // edge 35
        wr(A_MT, 32'hFFFF_FFFE);               // edge 37
        idle(1);
        rd(A_MT, 32'h0);                       // edge 40
        rd(A_MTH, 32'h1);                      // edge 42
        wr(A_MT, 32'h100);                     // edge 44, tick dropped
        rd(A_MT, 32'h101);                     // edge 46
        wr(A_MTH, 32'h5);                      // edge 48, tick dropped in low half
        rd(A_MT, 32'h104);                     // edge 50
        rd(A_MTH, 32'h5);                      // edge 52

        bad(32'hF000_0010, 1'b0);              // edge 54
        bad(32'hF000_0002, 1'b1);              // edge 56
        rd(A_MT, 32'h10C);                     // edge 58
        bad(32'hEFFF_FFFC, 1'b0);              // edge 60
        rd(A_CMP,  32'hFFFF_FFFF);             // edge 62
        rd(A_CMPH, 32'h0);                     // edge 64
        rd(A_MTH,  32'h5);                     // edge 66

        // Accept a read at edge 68, then reset during the response cycle.
        chk("ready_idle", 64'(m_rdy), 64'd1);
        req_valid = 1'b1;
        req_addr  = A_MT;
        req_wen   = 1'b0;
        push_exp(1'b0, 1'b1, 32'h116);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("resp_valid_after_reset", 64'(m_rsv), 64'd0);
        chk("ready_during_reset", 64'(m_rdy), 64'd0);
        reset = 1'b0;
        #1;
        rd(A_MT, 32'h0);                       // first edge after release
        rd(A_CMP,  32'hFFFF_FFFF);
        rd(A_CMPH, 32'hFFFF_FFFF);
        rd(A_MTH,  32'h0);
        chk("mtip_after_reset", 64'(m_mtip), 64'd0);
        rd(A_MT, 32'h8);                       // 9th edge after release

        // ---------------- TICK_DIV = 4 ----------------
        sel = 1'b1;
        do_reset();
        rd(A_MT, 32'h0);                       // edge 1
        rd(A_MT, 32'h0);                       // edge 3
        rd(A_MT, 32'h1);                       // edge 5 (tick at edge 4)
        wr(A_MT, 32'h0);                       // edge 7, not a tick edge
        idle(6);
        rd(A_MT, 32'h2);                       // edge 15
        idle(3);
        wr(A_MT, 32'h50);                      // edge 20, tick edge
        rd(A_MT, 32'h50);                      // edge 22
        rd(A_MT, 32'h50);                      // edge 24
        rd(A_MT, 32'h51);                      // edge 26

        idle(2);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
